// File: rtl/tpu_fp_pkg.sv
// Shared fp32 types and constants for the tpu datapath.
// Holds the fp32 type, the 1.0 constant and the power FSM states.
package tpu_fp_pkg;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SQR,
    DONE
  } pow_state_t;

endpackage

// File: rtl/multiply.sv
// Combinational fp32 multiplier, round-to-nearest-even.
// Ports: a, b operands; y product. Denormals flush to zero.
module multiply
  import tpu_fp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y
);

  logic              sy;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [22:0]       fa;
  logic [22:0]       fb;
  logic              a_nan;
  logic              b_nan;
  logic              a_inf;
  logic              b_inf;
  logic              a_zero;
  logic              b_zero;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_s;

  assign sy = a[31] ^ b[31];
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  always_comb begin
    prod   = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    exp_s  = $signed(10'(ea) + 10'(eb) - 10'd127);
    mant   = prod[45:23];
    guard  = prod[22];
    sticky = |prod[21:0];
    // product in [2,4): renormalise by one place
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = exp_s + 10'sd1;
    end
    inc    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + 24'(inc);
    // rounding carried out: fraction is already zero
    if (mant_r[23]) begin
      exp_s = exp_s + 10'sd1;
    end

    y = {sy, exp_s[7:0], mant_r[22:0]};
    if (a_nan || b_nan) begin
      y = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      if (a_zero || b_zero) y = 32'h7FC0_0000;
      else                  y = {sy, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      y = {sy, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      y = {sy, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      y = {sy, 31'd0};
    end
  end

endmodule

// File: rtl/fp32_power_seq.sv
// Sequential fp32 x^n by right-to-left square-and-multiply.
// Ports: clk, reset; in_valid/in_ready/in_x/in_n; out_valid/out_ready/out_pow/out_n.
module fp32_power_seq
  import tpu_fp_pkg::*;
#(
  parameter int          EXP_W  = 6,
  parameter logic [31:0] ONE_FP = FP_ONE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [EXP_W-1:0] in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pow,
  output logic [EXP_W-1:0] out_n
);

  pow_state_t       state;
  pow_state_t       state_d;
  fp32_t            res;
  fp32_t            res_d;
  fp32_t            base;
  fp32_t            base_d;
  logic [EXP_W-1:0] e;
  logic [EXP_W-1:0] e_d;
  logic [EXP_W-1:0] n_q;
  logic [EXP_W-1:0] n_q_d;
  fp32_t            mul_a;
  fp32_t            mul_b;
  fp32_t            mul_y;

  multiply u_mul (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      res   <= '0;
      base  <= '0;
      e     <= '0;
      n_q   <= '0;
    end else begin
      state <= state_d;
      res   <= res_d;
      base  <= base_d;
      e     <= e_d;
      n_q   <= n_q_d;
    end
  end

  always_comb begin
    state_d = state;
    res_d   = res;
    base_d  = base;
    e_d     = e;
    n_q_d   = n_q;
    mul_a   = res;
    mul_b   = base;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          res_d   = ONE_FP;
          base_d  = in_x;
          e_d     = in_n;
          n_q_d   = in_n;
          state_d = (in_n == '0) ? DONE : MUL;
        end
      end
      MUL: begin
        // zero bits still cost a MUL cycle so latency is data independent
        if (e[0]) res_d = mul_y;
        if (e[EXP_W-1:1] == '0) begin
          state_d = DONE;
        end else begin
          e_d     = e >> 1;
          state_d = SQR;
        end
      end
      SQR: begin
        mul_a   = base;
        base_d  = mul_y;
        state_d = MUL;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_pow   = (state == DONE) ? res : '0;
  assign out_n     = (state == DONE) ? n_q : '0;

endmodule

// File: tb/tb_fp32_power_seq.sv
// Directed and random checks of fp32_power_seq.
// Expected powers come from hand values and a real-arithmetic model.
module tb_fp32_power_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [5:0]  in_n;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pow;
  logic [5:0]  out_n;

  int checks   = 0;
  int failures = 0;

  fp32_power_seq #(.EXP_W(6), .ONE_FP(32'h3F80_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pow   (out_pow),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [5:0]  n;
    logic [31:0] pow;
    int          lat;
    int          hold;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:23] == 8'd0) return {f[31], 63'd0};
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [52:0] m;
    logic [24:0] k;
    logic        g;
    logic        st;
    int          ex;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF)
      return (d[51:0] != '0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
    m  = {1'b1, d[51:0]};
    g  = m[28];
    st = |m[27:0];
    k  = {1'b0, m[52:29]} + 25'(g & (st | m[29]));
    ex = int'(d[62:52]) - 1023 + 127;
    if (k[24]) begin
      ex++;
      k = k >> 1;
    end
    if (ex >= 255) return {d[63], 8'hFF, 23'd0};
    if (ex <= 0) return {d[63], 31'd0};
    return {d[63], 8'(ex), k[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    real p;
    p = $bitstoreal(f2d(a)) * $bitstoreal(f2d(b));
    return d2f($realtobits(p));
  endfunction

  function automatic logic [31:0] ref_pow(input logic [31:0] x,
                                          input logic [5:0] n);
    logic [31:0] r;
    logic [31:0] b;
    logic [5:0]  e;
    r = 32'h3F80_0000;
    b = x;
    e = n;
    if (n == 0) return r;
    forever begin
      if (e[0]) r = fmul(r, b);
      if ((e >> 1) == 0) break;
      e = e >> 1;
      b = fmul(b, b);
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [5:0] n);
    int k;
    logic [5:0] t;
    if (n == 0) return 1;
    k = 0;
    t = n;
    while (t > 1) begin
      t = t >> 1;
      k++;
    end
    return 2 * k + 2;
  endfunction

  task automatic run_req(input string tag, input logic [31:0] x,
                         input logic [5:0] n, input logic [31:0] exp_pow,
                         input int exp_lat, input int hold);
    int lat;
    check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_x     = x;
    in_n     = n;
    tick();
    in_valid = 1'b0;
    in_x     = 32'hDEAD_BEEF;
    in_n     = 6'h2A;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " out_pow"}, out_pow, exp_pow);
    check({tag, " out_n"}, 32'(out_n), 32'(n));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_x     = $urandom;
      in_n     = 6'($urandom);
      tick();
      in_valid = 1'b0;
      check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold_pow"}, out_pow, exp_pow);
      check({tag, " hold_n"}, 32'(out_n), 32'(n));
      check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " done_ready"}, 32'(in_ready), 32'd1);
    check({tag, " done_valid"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h4000_0000, 6'd10, 32'h4480_0000, 8, 0};
    vecs[1] = '{32'h3FC0_0000, 6'd3,  32'h4058_0000, 4, 0};
    vecs[2] = '{32'h7FC0_0000, 6'd0,  32'h3F80_0000, 1, 0};
    vecs[3] = '{32'hC0A0_0000, 6'd1,  32'hC0A0_0000, 2, 0};
    vecs[4] = '{32'h4000_0000, 6'd63, 32'h5F00_0000, 12, 0};
    vecs[5] = '{32'h4000_0000, 6'd32, 32'h4F80_0000, 12, 0};
    vecs[6] = '{32'h0000_0000, 6'd5,  32'h0000_0000, 6, 0};
    vecs[7] = '{32'hC000_0000, 6'd3,  32'hC100_0000, 4, 0};
    vecs[8] = '{32'h3FC0_0000, 6'd3,  32'h4058_0000, 4, 5};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_n      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_pow", out_pow, 32'd0);
    check("rst out_n", 32'(out_n), 32'd0);

    foreach (vecs[i])
      run_req($sformatf("vec%0d", i), vecs[i].x, vecs[i].n,
              vecs[i].pow, vecs[i].lat, vecs[i].hold);

    in_valid = 1'b1;
    in_x     = 32'h4000_0000;
    in_n     = 6'd63;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_pow", out_pow, 32'd0);
    run_req("after_abort", 32'h3FC0_0000, 6'd2, 32'h4010_0000, 4, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x;
      logic [5:0]  n;
      x = {1'($urandom), 8'($urandom_range(126, 128)), 23'($urandom)};
      n = 6'($urandom_range(0, 63));
      run_req($sformatf("rnd%0d", i), x, n, ref_pow(x, n), ref_lat(n),
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
